// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC. Steps +4, holds on stall, and redirects
// to resolved taken branch/jump targets, flushing IF/ID for FLUSH_CYCLES cycles.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        redirect_pending_o,
  output logic        misalign_o
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HOLD,
    S_FLUSH
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_pend;
  logic [CW-1:0] r_cnt;
  logic          r_pc_valid;
  logic          r_misalign;

  state_t        w_state_n;
  logic [31:0]   w_pc_n;
  logic [31:0]   w_pend_n;
  logic [CW-1:0] w_cnt_n;
  logic          w_misalign_n;
  logic          w_stall;
  logic          w_taken;
  logic          w_aligned;
  logic [31:0]   w_pc_inc;

  // The first cycle after reset release presents RESET_PC as valid before
  // stepping, so it behaves like a stall for the PC and redirect logic.
  assign w_stall   = stall_i | ~r_pc_valid;
  assign w_taken   = ex_valid_i & br_taken_i;
  assign w_aligned = (br_target_i[1:0] == 2'b00);
  assign w_pc_inc  = r_pc + 32'd4;

  // Next-state, next-PC and misalign pulse decode
  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_pend_n     = r_pend;
    w_cnt_n      = r_cnt;
    w_misalign_n = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_taken && w_aligned) begin
          if (w_stall) begin
            w_pend_n  = br_target_i;
            w_state_n = S_HOLD;
          end else begin
            w_pc_n    = br_target_i;
            w_cnt_n   = CNT_LOAD;
            w_state_n = S_FLUSH;
          end
        end else begin
          w_misalign_n = w_taken & ~w_aligned;
          if (!w_stall) w_pc_n = w_pc_inc;
        end
      end
      S_HOLD: begin
        if (!w_stall) begin
          w_pc_n    = r_pend;
          w_cnt_n   = CNT_LOAD;
          w_state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!w_stall) w_pc_n = w_pc_inc;
        w_cnt_n = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) w_state_n = S_RUN;
      end
      default: w_state_n = S_RUN;
    endcase
  end

  // State and PC registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_cnt      <= '0;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_pend     <= w_pend_n;
      r_cnt      <= w_cnt_n;
      r_pc_valid <= 1'b1;
      r_misalign <= w_misalign_n;
    end
  end

  // Flush/pending are pure decodes of the state register, so no input reaches them
  assign pc_o               = r_pc;
  assign pc_valid_o         = r_pc_valid;
  assign flush_if_o         = (r_state != S_RUN);
  assign flush_id_o         = (r_state != S_RUN);
  assign redirect_pending_o = (r_state == S_HOLD);
  assign misalign_o         = r_misalign;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed testbench for pc_redirect_unit: reference model plus literal checks.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FC     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        ex_valid_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        redirect_pending_o;
  logic        misalign_o;

  pc_redirect_unit #(
    .RESET_PC    (RST_PC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .ex_valid_i        (ex_valid_i),
    .br_taken_i        (br_taken_i),
    .br_target_i       (br_target_i),
    .pc_o              (pc_o),
    .pc_valid_o        (pc_valid_o),
    .flush_if_o        (flush_if_o),
    .flush_id_o        (flush_id_o),
    .redirect_pending_o(redirect_pending_o),
    .misalign_o        (misalign_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC, whether it is valid, flush cycles still owed,
  // a parked redirect target, and the misalign pulse.
  logic [31:0] m_pc    = '0;
  bit          m_valid = 0;
  int          m_left  = 0;
  bit          m_park  = 0;
  logic [31:0] m_ptgt  = '0;
  bit          m_mis   = 0;
  bit          m_known = 0;

  task automatic model_step(input bit rst, input bit stl, input bit exv,
                            input bit tk, input logic [31:0] tgt);
    bit busy;
    if (!rst) begin
      m_pc = RST_PC; m_valid = 0; m_left = 0; m_park = 0; m_ptgt = '0; m_mis = 0;
      m_known = 1;
      return;
    end
    busy  = stl || !m_valid;
    m_mis = 0;
    m_valid = 1;
    if (m_park) begin
      if (!busy) begin m_pc = m_ptgt; m_park = 0; m_left = FC; end
    end else if (m_left > 0) begin
      if (!busy) m_pc = m_pc + 32'd4;
      m_left = m_left - 1;
    end else if (exv && tk && (tgt % 4 == 0)) begin
      if (busy) begin m_park = 1; m_ptgt = tgt; end
      else begin m_pc = tgt; m_left = FC; end
    end else begin
      if (exv && tk) m_mis = 1;
      if (!busy) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc",       pc_o,                        m_pc);
      chk("valid",    {31'b0, pc_valid_o},         {31'b0, m_valid});
      chk("flush_if", {31'b0, flush_if_o},         {31'b0, (m_park || m_left > 0)});
      chk("flush_id", {31'b0, flush_id_o},         {31'b0, (m_park || m_left > 0)});
      chk("pending",  {31'b0, redirect_pending_o}, {31'b0, m_park});
      chk("misalign", {31'b0, misalign_o},         {31'b0, m_mis});
    end
  end

  // Apply one cycle of inputs; returns after the following falling edge
  task automatic cyc(input bit rst, input bit stl, input bit exv,
                     input bit tk, input logic [31:0] tgt);
    reset = rst; stall_i = stl; ex_valid_i = exv; br_taken_i = tk; br_target_i = tgt;
    @(posedge clk);
    model_step(rst, stl, exv, tk, tgt);
    n_vec++;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input bit fl,
                     input bit pend, input bit mis);
    chk({name, ".pc"},   pc_o,                        pc);
    chk({name, ".fl"},   {31'b0, flush_if_o},         {31'b0, fl});
    chk({name, ".pend"}, {31'b0, redirect_pending_o}, {31'b0, pend});
    chk({name, ".mis"},  {31'b0, misalign_o},         {31'b0, mis});
  endtask

  initial begin
    reset = 1'b0; stall_i = 1'b0; ex_valid_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;
    @(negedge clk);
    // T1 reset and release
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    lit("t1_rst", 32'h0, 0, 0, 0);
    chk("t1_rst.valid", {31'b0, pc_valid_o}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    lit("t1_c0", 32'h0, 0, 0, 0);
    chk("t1_c0.valid", {31'b0, pc_valid_o}, 32'h1);
    cyc(1, 0, 0, 0, 0);  lit("t1_c1", 32'h4, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);  lit("t1_c2", 32'h8, 0, 0, 0);
    // T2 redirect, T5 second taken inside the flush window is ignored
    cyc(1, 0, 1, 1, 32'h100); lit("t2_n1", 32'h100, 1, 0, 0);
    cyc(1, 0, 1, 1, 32'h300); lit("t5_n2", 32'h104, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);       lit("t2_n3", 32'h108, 0, 0, 0);
    // taken but ex_valid low: no redirect
    cyc(1, 0, 0, 1, 32'h500); lit("nv",    32'h10C, 0, 0, 0);
    // T4 misaligned target
    cyc(1, 0, 1, 1, 32'h102); lit("t4_a",  32'h110, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);       lit("t4_b",  32'h114, 0, 0, 0);
    // T3 stalled redirect
    cyc(1, 1, 1, 1, 32'h200); lit("t3_h1", 32'h114, 1, 1, 0);
    cyc(1, 1, 1, 1, 32'h600); lit("t3_h2", 32'h114, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);       lit("t3_h3", 32'h114, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);       lit("t3_ld", 32'h200, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);       lit("t3_f2", 32'h204, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);       lit("t3_rn", 32'h208, 0, 0, 0);
    // stall in RUN holds
    cyc(1, 1, 0, 0, 0);       lit("stall", 32'h208, 0, 0, 0);
    // flush counter runs down even while stalled
    cyc(1, 0, 1, 1, 32'h400); lit("fs_1",  32'h400, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);       lit("fs_2",  32'h400, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);       lit("fs_3",  32'h400, 0, 0, 0);
    // T6 wrap
    cyc(1, 0, 1, 1, 32'hFFFF_FFF4); lit("w1", 32'hFFFF_FFF4, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);             lit("w2", 32'hFFFF_FFF8, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);             lit("w3", 32'hFFFF_FFFC, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);             lit("w4", 32'h0000_0000, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);             lit("w5", 32'h0000_0004, 0, 0, 0);
    // T6 reset in HOLD
    cyc(1, 1, 1, 1, 32'h800); lit("rh_h", 32'h4, 1, 1, 0);
    cyc(0, 1, 1, 1, 32'h900); lit("rh_r", 32'h0, 0, 0, 0);
    chk("rh_r.valid", {31'b0, pc_valid_o}, 32'h0);
    cyc(1, 0, 0, 0, 0);       lit("rh_1", 32'h0, 0, 0, 0);
    chk("rh_1.valid", {31'b0, pc_valid_o}, 32'h1);
    cyc(1, 0, 0, 0, 0);       lit("rh_2", 32'h4, 0, 0, 0);
    // reset during FLUSH
    cyc(1, 0, 1, 1, 32'h40);  lit("rf_1", 32'h40, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);       lit("rf_r", 32'h0,  0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);       lit("rf_2", 32'h4,  0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
